// File: rtl/ps2_scancode_fifo.sv
// PS/2 set-2 make-code decoder feeding a first-word-fall-through ASCII FIFO.
// Break (F0 xx) and extended (E0 ..) sequences are swallowed; Esc flushes the FIFO.
module ps2_scancode_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ps2_received_data,
    input  logic              ps2_received_data_strb,
    output logic [7:0]        char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_EXT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_push_req;
    logic               w_flush;
    logic [7:0]         w_ascii;
    logic               w_mapped;

    logic [7:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    logic [7:0]         r_char_data;
    logic               r_overflow;

    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_empty_after_pop;
    logic [ADDR_W-1:0]  w_rd_next;
    logic [CNT_W-1:0]   w_count_next;

    // Set-2 make code to ASCII; bit 8 flags a code we translate.
    function automatic logic [8:0] map_code(input logic [7:0] code);
        logic [8:0] res;
        res = 9'h000;
        case (code)
            8'h1C: res = {1'b1, 8'h41};
            8'h32: res = {1'b1, 8'h42};
            8'h21: res = {1'b1, 8'h43};
            8'h23: res = {1'b1, 8'h44};
            8'h24: res = {1'b1, 8'h45};
            8'h2B: res = {1'b1, 8'h46};
            8'h34: res = {1'b1, 8'h47};
            8'h33: res = {1'b1, 8'h48};
            8'h43: res = {1'b1, 8'h49};
            8'h3B: res = {1'b1, 8'h4A};
            8'h42: res = {1'b1, 8'h4B};
            8'h4B: res = {1'b1, 8'h4C};
            8'h3A: res = {1'b1, 8'h4D};
            8'h31: res = {1'b1, 8'h4E};
            8'h44: res = {1'b1, 8'h4F};
            8'h4D: res = {1'b1, 8'h50};
            8'h15: res = {1'b1, 8'h51};
            8'h2D: res = {1'b1, 8'h52};
            8'h1B: res = {1'b1, 8'h53};
            8'h2C: res = {1'b1, 8'h54};
            8'h3C: res = {1'b1, 8'h55};
            8'h2A: res = {1'b1, 8'h56};
            8'h1D: res = {1'b1, 8'h57};
            8'h22: res = {1'b1, 8'h58};
            8'h35: res = {1'b1, 8'h59};
            8'h1A: res = {1'b1, 8'h5A};
            8'h45: res = {1'b1, 8'h30};
            8'h16: res = {1'b1, 8'h31};
            8'h1E: res = {1'b1, 8'h32};
            8'h26: res = {1'b1, 8'h33};
            8'h25: res = {1'b1, 8'h34};
            8'h2E: res = {1'b1, 8'h35};
            8'h36: res = {1'b1, 8'h36};
            8'h3D: res = {1'b1, 8'h37};
            8'h3E: res = {1'b1, 8'h38};
            8'h46: res = {1'b1, 8'h39};
            8'h29: res = {1'b1, 8'h20};
            default: res = 9'h000;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Prefix tracking: only bytes seen in S_IDLE can push or flush.
    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_flush      = 1'b0;
        {w_mapped, w_ascii} = map_code(ps2_received_data);
        if (ps2_received_data_strb) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_received_data == 8'hF0) begin
                        w_state_next = S_BREAK;
                    end else if (ps2_received_data == 8'hE0) begin
                        w_state_next = S_EXT;
                    end else if (ps2_received_data == 8'h76) begin
                        w_flush = 1'b1;
                    end else begin
                        w_push_req = w_mapped;
                    end
                end
                S_BREAK: w_state_next = S_IDLE;
                S_EXT:   w_state_next = (ps2_received_data == 8'hF0) ? S_BREAK : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pop             = r_valid && char_ready;
        w_full            = (r_count == CNT_W'(DEPTH));
        w_push            = w_push_req && !w_full;
        w_rd_next         = w_pop ? (r_rd_ptr + ADDR_W'(1)) : r_rd_ptr;
        w_count_next      = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_empty_after_pop = (r_count == CNT_W'(w_pop));
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= w_ascii;
        end
    end

    // Head register: a push into an (effectively) empty FIFO bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_char_data <= 8'h00;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
                r_valid  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                r_rd_ptr <= w_rd_next;
                r_count  <= w_count_next;
                r_valid  <= (w_count_next != '0);
                if (w_count_next != '0) begin
                    r_char_data <= (w_push && w_empty_after_pop) ? w_ascii : r_mem[w_rd_next];
                end
            end
        end
    end

    assign char_data  = r_char_data;
    assign char_valid = r_valid;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the scan-code rules.
module tb_ps2_scancode_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic [7:0]        ps2_received_data;
    logic              ps2_received_data_strb;
    logic [7:0]        char_data;
    logic              char_valid;
    logic              char_ready;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;

    int checks;
    int errors;

    // Reference model state
    logic [7:0] m_q[$];
    int         m_pre;      // 0 none, 1 after F0, 2 after E0
    logic       m_ovf;
    logic [7:0] m_data;

    logic [7:0] codes [37];
    logic [7:0] ascii [37];

    ps2_scancode_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_received_data      (ps2_received_data),
        .ps2_received_data_strb (ps2_received_data_strb),
        .char_data              (char_data),
        .char_valid             (char_valid),
        .char_ready             (char_ready),
        .fifo_count             (fifo_count),
        .overflow               (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void build_map();
        logic [7:0] let_c [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_c [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) begin
            codes[i] = let_c[i];
            ascii[i] = 8'(8'h41 + i);
        end
        for (int i = 0; i < 10; i++) begin
            codes[26 + i] = dig_c[i];
            ascii[26 + i] = 8'(8'h30 + i);
        end
        codes[36] = 8'h29;
        ascii[36] = 8'h20;
    endfunction

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 37; i++) begin
            if (codes[i] == b) return int'(ascii[i]);
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_pre  = 0;
        m_ovf  = 1'b0;
        m_data = 8'h00;
    endfunction

    // One clock: drive at negedge, update model, sample at the following negedge.
    task automatic step(input logic [7:0] b, input bit s, input bit rdy);
        bit pop, push, flush, full;
        int a;
        ps2_received_data      = b;
        ps2_received_data_strb = s;
        char_ready             = rdy;
        pop   = (m_q.size() > 0) && rdy;
        push  = 1'b0;
        flush = 1'b0;
        a     = lookup(b);
        if (s) begin
            case (m_pre)
                0: begin
                    if (b == 8'hF0) m_pre = 1;
                    else if (b == 8'hE0) m_pre = 2;
                    else if (b == 8'h76) flush = 1'b1;
                    else if (a >= 0) push = 1'b1;
                end
                1: m_pre = 0;
                default: m_pre = (b == 8'hF0) ? 1 : 0;
            endcase
        end
        if (flush) begin
            m_q.delete();
        end else begin
            full = (m_q.size() == DEPTH);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (full) m_ovf = 1'b1;
                else m_q.push_back(8'(a));
            end
        end
        if (m_q.size() > 0) m_data = m_q[0];
        @(posedge clk);
        @(negedge clk);
        ps2_received_data_strb = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) begin
            step(8'h00, 1'b0, 1'b1);
            checks++;
            if ({char_valid, char_data, fifo_count, overflow} !==
                {m_q.size() > 0, m_data, 4'(m_q.size()), m_ovf}) begin
                errors++;
                $display("FAIL drain: got v=%0b d=%h c=%0d o=%0b want v=%0b d=%h c=%0d o=%0b",
                         char_valid, char_data, fifo_count, overflow,
                         m_q.size() > 0, m_data, m_q.size(), m_ovf);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ps2_received_data = 8'h00;
        ps2_received_data_strb = 1'b0;
        char_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({char_valid, char_data, fifo_count, overflow} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got v=%0b d=%h c=%0d o=%0b want all zero",
                     char_valid, char_data, fifo_count, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_press_release();
        step(8'h1C, 1'b1, 1'b0);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h41) begin
            errors++;
            $display("FAIL press_head: got v=%0b d=%h want v=1 d=41", char_valid, char_data);
        end
        step(8'h00, 1'b0, 1'b0);
        step(8'hF0, 1'b1, 1'b0);
        step(8'h1C, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        checks++;
        if (fifo_count !== 4'd1 || char_data !== 8'h41) begin
            errors++;
            $display("FAIL release_ignored: got c=%0d d=%h want c=1 d=41", fifo_count, char_data);
        end
        drain();
    endtask

    task automatic test_extended();
        logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) step(seq[i], 1'b1, 1'b0);
        checks++;
        if (char_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL extended_ignored: got v=%0b c=%0d want v=0 c=0", char_valid, fifo_count);
        end
        step(8'h45, 1'b1, 1'b0);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h30) begin
            errors++;
            $display("FAIL after_extended: got v=%0b d=%h want v=1 d=30", char_valid, char_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_list [DEPTH];
        int idx;
        for (int i = 0; i < DEPTH + 1; i++) begin
            idx = $urandom_range(36);
            if (i < DEPTH) exp_list[i] = ascii[idx];
            step(codes[idx], 1'b1, 1'b0);
        end
        checks++;
        if (fifo_count !== 4'(DEPTH) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: got c=%0d o=%0b want c=%0d o=1", fifo_count, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (char_valid !== 1'b1 || char_data !== exp_list[i]) begin
                errors++;
                $display("FAIL overflow_order[%0d]: got v=%0b d=%h want v=1 d=%h",
                         i, char_valid, char_data, exp_list[i]);
            end
            step(8'h00, 1'b0, 1'b1);
        end
        checks++;
        if (char_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained: got v=%0b c=%0d o=%0b want v=0 c=0 o=1",
                     char_valid, fifo_count, overflow);
        end
    endtask

    task automatic test_push_pop();
        step(8'h1C, 1'b1, 1'b0);
        step(8'h29, 1'b1, 1'b1);
        checks++;
        if (fifo_count !== 4'd1 || char_data !== 8'h20 || char_valid !== 1'b1) begin
            errors++;
            $display("FAIL push_pop: got v=%0b c=%0d d=%h want v=1 c=1 d=20",
                     char_valid, fifo_count, char_data);
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(codes[$urandom_range(36)], 1'b1, 1'b0);
        step(8'h76, 1'b1, 1'b1);
        checks++;
        if (char_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== m_ovf) begin
            errors++;
            $display("FAIL flush: got v=%0b c=%0d o=%0b want v=0 c=0 o=%0b",
                     char_valid, fifo_count, overflow, m_ovf);
        end
        step(8'h2D, 1'b1, 1'b0);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h52 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL after_flush: got v=%0b d=%h c=%0d want v=1 d=52 c=1",
                     char_valid, char_data, fifo_count);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(codes[$urandom_range(36)], 1'b1, 1'b0);
        step(8'hF0, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({char_valid, char_data, fifo_count, overflow} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b d=%h c=%0d o=%0b want all zero",
                     char_valid, char_data, fifo_count, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(8'h1C, 1'b1, 1'b0);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h41 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL reset_prefix_dropped: got v=%0b d=%h c=%0d want v=1 d=41 c=1",
                     char_valid, char_data, fifo_count);
        end
        drain();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        bit s, rdy;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(99);
            if (r < 45)      b = codes[$urandom_range(36)];
            else if (r < 57) b = 8'hF0;
            else if (r < 67) b = 8'hE0;
            else if (r < 70) b = 8'h76;
            else             b = 8'($urandom);
            s   = ($urandom_range(99) < 60);
            rdy = ($urandom_range(99) < ((n / 100) % 2 == 0 ? 25 : 70));
            step(b, s, rdy);
            checks++;
            if ({char_valid, char_data, fifo_count, overflow} !==
                {m_q.size() > 0, m_data, 4'(m_q.size()), m_ovf}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b d=%h c=%0d o=%0b want v=%0b d=%h c=%0d o=%0b",
                         n, char_valid, char_data, fifo_count, overflow,
                         m_q.size() > 0, m_data, m_q.size(), m_ovf);
            end
        end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        build_map();
        test_reset();
        test_press_release();
        test_extended();
        test_push_pop();
        test_flush();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
